datapath_word_unpacker: RTL and testbench

DATAPATH_WORD_UNPACKER -- requirements
Module: datapath_word_unpacker

---
 rtl/datapath_word_unpacker.sv | 191 +++++++++++++++++++
 tb/tb_datapath_word_unpacker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_word_unpacker.sv
// -----------------------------------------------------------------------------
// datapath_word_unpacker
//   Unpacks WORD_W-bit words from a paced upstream FIFO into SAMPLE_W-bit
//   samples, MSB slice first, one sample every SAMPLE_DIV clocks. A shadow
//   register holds the next word while the active shift register drains. When
//   the shadow is full at the end of a word, the two are swapped on the same
//   edge, so back-to-back words come out without a gap.
//
//   Optional build macro: DATAPATH_UNPACK_STATS_EN. When it is defined, the
//   words_done counter and the overrun flag are implemented. When it is not
//   defined, both outputs are tied to 0.
//
// Ports
//   clk, rstn        clock; asynchronous active-low reset
//   enable           stream run request (gates rd_req only)
//   clear_status     clears underrun/overrun (a set in the same cycle wins)
//   rd_req           combinational read request to the upstream FIFO
//   word_strobe      upstream read accept; word_in is valid the next cycle
//   word_in          packed word from the upstream FIFO
//   sample_out       current sample, held between pulses
//   sample_valid     one-cycle pulse per new sample
//   busy             shifting, or a word is waiting in the shadow
//   underrun         sticky: the stream ran dry while enable was high
//   overrun          sticky: a word arrived while the shadow was full
//   words_done       count of fully emitted words (wraps at 16 bits)
// -----------------------------------------------------------------------------
module datapath_word_unpacker #(
    parameter int WORD_W     = 192,
    parameter int SAMPLE_W   = 64,
    parameter int SAMPLE_DIV = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic                clear_status,
    output logic                rd_req,
    input  logic                word_strobe,
    input  logic [WORD_W-1:0]   word_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                underrun,
    output logic                overrun,
    output logic [15:0]         words_done
);

    localparam int NSAMP = WORD_W / SAMPLE_W;
    localparam int IDX_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shadow_q;
    logic [WORD_W-1:0] shift_q;
    logic              shadow_full_q;
    logic              cap_pending_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DIV_W-1:0]  div_q;

    logic div_last, idx_last;
    logic load, advance, word_end;
    logic underrun_set;

    assign div_last = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign idx_last = (idx_q == IDX_W'(NSAMP - 1));

    // Hold off the request while a word is still in flight. That covers the
    // accept cycle, the capture cycle and a full shadow, so that the upstream
    // never overruns us when it honours rd_req.
    assign rd_req = rstn & enable & ~shadow_full_q & ~cap_pending_q & ~word_strobe;

    assign busy = (state_q == S_SHIFT) | shadow_full_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        advance  = 1'b0;
        word_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (shadow_full_q) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_last) begin
                    if (idx_last) begin
                        // The next sample would be NSAMP. Swap in the shadow
                        // on this same edge if a word is waiting there.
                        word_end = 1'b1;
                        if (shadow_full_q) load = 1'b1;
                        else               state_d = S_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------ capture / shadow
    // A capture that lands on a full shadow is dropped. This applies even on
    // the edge where the shadow is being consumed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_pending_q <= 1'b0;
            shadow_full_q <= 1'b0;
            shadow_q      <= '0;
        end else begin
            cap_pending_q <= word_strobe;
            if (cap_pending_q && !shadow_full_q) begin
                shadow_q      <= word_in;
                shadow_full_q <= 1'b1;
            end else if (load) begin
                shadow_full_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------ shift datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            idx_q        <= '0;
            div_q        <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (load) begin
                // Sample 0 goes straight out of the shadow. The shift register
                // keeps the remaining slices, already moved to the top.
                shift_q      <= shadow_q << SAMPLE_W;
                sample_out   <= shadow_q[WORD_W-1 -: SAMPLE_W];
                sample_valid <= 1'b1;
                idx_q        <= '0;
                div_q        <= '0;
            end else if (state_q == S_SHIFT) begin
                if (div_last) begin
                    div_q <= '0;
                    if (advance) begin
                        idx_q        <= idx_q + 1'b1;
                        sample_out   <= shift_q[WORD_W-1 -: SAMPLE_W];
                        shift_q      <= shift_q << SAMPLE_W;
                        sample_valid <= 1'b1;
                    end
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------ status
    // A word that ends with nothing waiting is an underrun, but only while
    // the stream is still requested. A drain after enable drops is clean.
    assign underrun_set = word_end & ~shadow_full_q & enable;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) underrun <= 1'b0;
        else       underrun <= underrun_set | (underrun & ~clear_status);
    end

`ifdef DATAPATH_UNPACK_STATS_EN
    logic overrun_set;
    assign overrun_set = cap_pending_q & shadow_full_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun    <= 1'b0;
            words_done <= '0;
        end else begin
            overrun <= overrun_set | (overrun & ~clear_status);
            if (word_end) words_done <= words_done + 16'd1;
        end
    end
`else
    assign overrun    = 1'b0;
    assign words_done = '0;
`endif

endmodule

// File: tb/tb_datapath_word_unpacker.sv
// -----------------------------------------------------------------------------
// tb_datapath_word_unpacker
//   Directed test of datapath_word_unpacker with default parameters
//   (192-bit words, 64-bit samples, 10 clocks per sample). Cycle 0 of each
//   scenario is the cycle in which the first strobe is driven.
// -----------------------------------------------------------------------------
module tb_datapath_word_unpacker;

`ifdef DATAPATH_UNPACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn, enable, clear_status, word_strobe;
    logic         rd_req, sample_valid, busy, underrun, overrun;
    logic [191:0] word_in;
    logic [63:0]  sample_out;
    logic [15:0]  words_done;

    always #5 clk = ~clk;

    datapath_word_unpacker dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .clear_status (clear_status),
        .rd_req       (rd_req),
        .word_strobe  (word_strobe),
        .word_in      (word_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .underrun     (underrun),
        .overrun      (overrun),
        .words_done   (words_done)
    );

    int total = 0, passed = 0, fails = 0;

    int           sc[4];
    logic [191:0] sw[4];
    int           nstb, en_off, clr0, clr1;
    logic         rd_log[200], und_log[200], busy_log[200], ovr_log[200];
    int           pc[$], ec[$];
    logic [63:0]  pv[$], ev[$];

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lane(input int k, input int s);
        return 64'hCAFE_0000_0000_0000 | 64'(k * 16 + s + 1);
    endfunction

    function automatic logic [191:0] mkword(input int k);
        return {lane(k, 0), lane(k, 1), lane(k, 2)};
    endfunction

    task automatic setup();
        nstb = 0; en_off = 1000; clr0 = -1; clr1 = -1;
        ec.delete(); ev.delete();
        enable = 1'b1;
    endtask

    task automatic add_strobe(input int c, input logic [191:0] w);
        sc[nstb] = c; sw[nstb] = w; nstb++;
    endtask

    task automatic expect_word(input int start, input logic [191:0] w);
        for (int s = 0; s < 3; s++) begin
            ec.push_back(start + 10 * s);
            ev.push_back(w[191 - 64 * s -: 64]);
        end
    endtask

    // Drive ncyc cycles. Each cycle: apply inputs, record rd_req with the
    // strobe still low, then raise the strobe if one is scheduled, log the
    // registered outputs, and step to the next posedge.
    task automatic run(input int ncyc);
        pc.delete(); pv.delete();
        for (int c = 0; c < ncyc; c++) begin
            int k;
            k = -1;
            for (int j = 0; j < nstb; j++) if (sc[j] == c) k = j;
            word_strobe  = 1'b0;
            enable       = (c < en_off);
            clear_status = (c == clr0) || (c == clr1);
            #1;
            rd_log[c] = rd_req;
            if (k >= 0) begin
                word_strobe = 1'b1;
                word_in     = sw[k];
            end
            if (sample_valid) begin
                pc.push_back(c);
                pv.push_back(sample_out);
            end
            und_log[c]  = underrun;
            busy_log[c] = busy;
            ovr_log[c]  = overrun;
            @(posedge clk); #2;
        end
        word_strobe  = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic check_samples(input string tag);
        check({tag, "_count"}, 192'(pc.size()), 192'(ec.size()));
        for (int i = 0; i < ec.size() && i < pc.size(); i++)
            check($sformatf("%s_s%0d", tag, i), 192'({32'(pc[i]), pv[i]}),
                  192'({32'(ec[i]), ev[i]}));
    endtask

    task automatic do_reset();
        @(negedge clk) rstn = 1'b0;
        #2 rstn = 1'b1;
        @(posedge clk); #2;
    endtask

    initial begin
        int           ones;
        logic [191:0] w1;

        // ---------------- reset state
        rstn = 1'b0; enable = 1'b1; clear_status = 1'b0;
        word_strobe = 1'b0; word_in = '0;
        #1;
        check("reset_rd_req", 192'(rd_req), 192'(0));
        check("reset_outputs", 192'({sample_out, sample_valid, busy, underrun, overrun, words_done}), 192'(0));
        repeat (2) @(posedge clk);
        #2 check("reset_rd_req_hold", 192'(rd_req), 192'(0));
        @(negedge clk) rstn = 1'b1;
        #1 check("release_rd_req", 192'(rd_req), 192'(1));
        @(posedge clk); #2;

        // ---------------- single word, latency, underrun with clear/set overlap
        setup();
        w1 = {{16{4'h1}}, {16{4'h2}}, {16{4'h3}}};
        add_strobe(0, w1);
        expect_word(3, w1);
        clr0 = 32; clr1 = 34;
        run(40);
        check_samples("single");
        check("single_rd_req_c0", 192'(rd_log[0]), 192'(1));
        check("single_rd_req_c1", 192'(rd_log[1]), 192'(0));
        check("single_rd_req_c3", 192'(rd_log[3]), 192'(1));
        check("single_busy_c32", 192'(busy_log[32]), 192'(1));
        check("single_busy_c33", 192'(busy_log[33]), 192'(0));
        check("single_underrun_c32", 192'(und_log[32]), 192'(0));
        check("single_underrun_set_wins", 192'(und_log[33]), 192'(1));
        check("single_underrun_sticky", 192'(und_log[34]), 192'(1));
        check("single_underrun_clear", 192'(und_log[35]), 192'(0));
        check("single_sample_hold", 192'(sample_out), 192'(w1[63:0]));
        check("single_words_done", 192'(words_done), STATS ? 192'(1) : 192'(0));

        // ---------------- paced stream of four words
        do_reset();
        setup();
        for (int k = 0; k < 4; k++) begin
            add_strobe(30 * k, mkword(k));
            expect_word(3 + 30 * k, mkword(k));
        end
        run(130);
        for (int k = 0; k < 4; k++)
            check($sformatf("paced_rd_req_w%0d", k), 192'(rd_log[30 * k]), 192'(1));
        check_samples("paced");
        check("paced_underrun_c122", 192'(und_log[122]), 192'(0));
        check("paced_underrun_c123", 192'(und_log[123]), 192'(1));
        check("paced_words_done", 192'(words_done), STATS ? 192'(4) : 192'(0));

        // ---------------- forced strobe onto a full shadow
        do_reset();
        setup();
        add_strobe(0, mkword(4));
        add_strobe(3, mkword(5));
        add_strobe(6, mkword(6));
        expect_word(3, mkword(4));
        expect_word(33, mkword(5));
        run(70);
        check("ovr_rd_req_c6", 192'(rd_log[6]), 192'(0));
        check("ovr_flag_c7", 192'(ovr_log[7]), 192'(0));
        check("ovr_flag_c8", 192'(ovr_log[8]), STATS ? 192'(1) : 192'(0));
        check_samples("ovr");
        check("ovr_words_done", 192'(words_done), STATS ? 192'(2) : 192'(0));

        // ---------------- enable drop during word A, with B shadowed
        do_reset();
        setup();
        add_strobe(0, mkword(7));
        add_strobe(3, mkword(8));
        expect_word(3, mkword(7));
        expect_word(33, mkword(8));
        en_off = 14;
        run(70);
        ones = 0;
        for (int c = 14; c < 70; c++) ones += int'(rd_log[c]);
        check("drain_rd_req_low", 192'(ones), 192'(0));
        check_samples("drain");
        check("drain_busy_c62", 192'(busy_log[62]), 192'(1));
        check("drain_busy_c63", 192'(busy_log[63]), 192'(0));
        check("drain_underrun", 192'(und_log[69]), 192'(0));
        check("drain_words_done", 192'(words_done), STATS ? 192'(2) : 192'(0));

        // ---------------- reset in the middle of SHIFT
        do_reset();
        setup();
        add_strobe(0, mkword(9));
        add_strobe(3, mkword(10));
        run(20);
        check("midrst_busy_before", 192'(busy), 192'(1));
        rstn = 1'b0;
        #1;
        check("midrst_outputs_zero",
              192'({sample_out, sample_valid, busy, underrun, overrun, words_done, rd_req}), 192'(0));
        @(negedge clk) rstn = 1'b1;
        #1 check("midrst_rd_req_release", 192'(rd_req), 192'(1));
        @(posedge clk); #2;
        setup();
        add_strobe(0, mkword(11));
        expect_word(3, mkword(11));
        run(40);
        check_samples("midrst");
        check("midrst_words_done", 192'(words_done), STATS ? 192'(1) : 192'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
